// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter
//   Arbitrates three writeback requesters (jal link, ALU, load) onto the
//   single register-file write port and flags read-after-write hazards for
//   the instruction currently being decoded.
//
// Ports
//   clk, rst_n                     clock, synchronous active-low reset
//   alu_valid/alu_reg/alu_data     ALU writeback request   -> alu_ready
//   mem_valid/mem_reg/mem_data     load writeback request  -> mem_ready
//   lnk_valid/lnk_data             jal link request (r31)  -> lnk_ready
//   rd_rs, rd_rt                   decoding instruction sources -> hazard
//   reg_write, jal                 one-cycle write strobes (registered)
//   write_reg, write_data          register-file write address / data
//   wr_count                       count of issued writes (wraps)
module reg_write_arbiter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alu_valid,
  input  logic [4:0]       alu_reg,
  input  logic [31:0]      alu_data,
  output logic             alu_ready,
  input  logic             mem_valid,
  input  logic [4:0]       mem_reg,
  input  logic [31:0]      mem_data,
  output logic             mem_ready,
  input  logic             lnk_valid,
  input  logic [31:0]      lnk_data,
  output logic             lnk_ready,
  input  logic [4:0]       rd_rs,
  input  logic [4:0]       rd_rt,
  output logic             hazard,
  output logic             reg_write,
  output logic             jal,
  output logic [4:0]       write_reg,
  output logic [31:0]      write_data,
  output logic [CNT_W-1:0] wr_count
);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t             state_q, state_d;
  logic               rr_ptr_q;
  logic               pend_wr_q;
  logic               pend_jal_q;
  logic [4:0]         write_reg_q;
  logic [31:0]        write_data_q;
  logic [CNT_W-1:0]   wr_count_q;
  logic               xfer;
  logic               rs_hit, rt_hit;

  // Grant: link always wins; alu/mem share by round-robin only when both ask.
  always_comb begin
    lnk_ready = 1'b0;
    alu_ready = 1'b0;
    mem_ready = 1'b0;
    if (rst_n) begin
      if (lnk_valid) begin
        lnk_ready = 1'b1;
      end else if (alu_valid && mem_valid) begin
        if (rr_ptr_q) mem_ready = 1'b1;
        else          alu_ready = 1'b1;
      end else begin
        alu_ready = alu_valid;
        mem_ready = mem_valid;
      end
    end
  end

  assign xfer = lnk_ready | alu_ready | mem_ready;

  // Output stage: strobes are only asserted while in ISSUE; a dropped
  // (target 0) transfer still passes through ISSUE with both pend flags low.
  always_comb begin
    state_d   = IDLE;
    reg_write = 1'b0;
    jal       = 1'b0;
    if (xfer) state_d = ISSUE;
    if (state_q == ISSUE) begin
      reg_write = pend_wr_q;
      jal       = pend_jal_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rr_ptr_q     <= 1'b0;
      pend_wr_q    <= 1'b0;
      pend_jal_q   <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
      wr_count_q   <= '0;
    end else begin
      state_q    <= state_d;
      pend_jal_q <= lnk_ready;
      pend_wr_q  <= (alu_ready && (alu_reg != 5'd0)) ||
                    (mem_ready && (mem_reg != 5'd0));
      if (alu_ready)      rr_ptr_q <= 1'b1;
      else if (mem_ready) rr_ptr_q <= 1'b0;
      // Address/data only move on a real write so they hold otherwise.
      if (lnk_ready) begin
        write_reg_q  <= 5'd31;
        write_data_q <= lnk_data;
      end else if (alu_ready && (alu_reg != 5'd0)) begin
        write_reg_q  <= alu_reg;
        write_data_q <= alu_data;
      end else if (mem_ready && (mem_reg != 5'd0)) begin
        write_reg_q  <= mem_reg;
        write_data_q <= mem_data;
      end
      if (reg_write || jal) wr_count_q <= wr_count_q + CNT_W'(1);
    end
  end

  assign write_reg  = write_reg_q;
  assign write_data = write_data_q;
  assign wr_count   = wr_count_q;

  // Hazard against every register that is requested or being written now.
  always_comb begin
    rs_hit = (rd_rs != 5'd0) &&
             ((alu_valid && (rd_rs == alu_reg)) ||
              (mem_valid && (rd_rs == mem_reg)) ||
              (lnk_valid && (rd_rs == 5'd31))   ||
              ((reg_write || jal) && (rd_rs == write_reg_q)));
    rt_hit = (rd_rt != 5'd0) &&
             ((alu_valid && (rd_rt == alu_reg)) ||
              (mem_valid && (rd_rt == mem_reg)) ||
              (lnk_valid && (rd_rt == 5'd31))   ||
              ((reg_write || jal) && (rd_rt == write_reg_q)));
    hazard = rs_hit || rt_hit;
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb_reg_write_arbiter
//   Queue-driven requesters feed the arbiter; a cycle-level reference model
//   predicts grants, strobes, write port contents, counter and hazard.
module tb_reg_write_arbiter;

  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          alu_valid, mem_valid, lnk_valid;
  logic [4:0]    alu_reg, mem_reg;
  logic [31:0]   alu_data, mem_data, lnk_data;
  logic          alu_ready, mem_ready, lnk_ready;
  logic [4:0]    rd_rs, rd_rt;
  logic          hazard, reg_write, jal;
  logic [4:0]    write_reg;
  logic [31:0]   write_data;
  logic [CW-1:0] wr_count;

  reg_write_arbiter #(.CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_reg(mem_reg), .mem_data(mem_data), .mem_ready(mem_ready),
    .lnk_valid(lnk_valid), .lnk_data(lnk_data), .lnk_ready(lnk_ready),
    .rd_rs(rd_rs), .rd_rt(rd_rt), .hazard(hazard),
    .reg_write(reg_write), .jal(jal), .write_reg(write_reg), .write_data(write_data),
    .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
  } req_t;

  req_t alu_q[$], mem_q[$], lnk_q[$];

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Reference model state
  bit          m_rr;
  bit          m_wr, m_jal;
  logic [4:0]  m_wreg;
  logic [31:0] m_wdata;
  int unsigned m_count;

  bit drop_alu, drop_mem, drop_lnk;
  bit held_alu, held_mem, held_lnk;
  logic [36:0] snap_alu, snap_mem;
  logic [31:0] snap_lnk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit exp_hazard(input logic [4:0] rs, input logic [4:0] rt);
    logic [4:0] busy[$];
    if (alu_valid) busy.push_back(alu_reg);
    if (mem_valid) busy.push_back(mem_reg);
    if (lnk_valid) busy.push_back(5'd31);
    if (m_wr || m_jal) busy.push_back(m_wreg);
    foreach (busy[i]) begin
      if (rs != 0 && rs == busy[i]) return 1'b1;
      if (rt != 0 && rt == busy[i]) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic cycle(input logic [4:0] rs, input logic [4:0] rt, input logic rst);
    string who;
    req_t  e;
    @(negedge clk);
    check("reg_write",  {63'd0, reg_write}, {63'd0, m_wr});
    check("jal",        {63'd0, jal},       {63'd0, m_jal});
    check("write_reg",  {59'd0, write_reg}, {59'd0, m_wreg});
    check("write_data", {32'd0, write_data}, {32'd0, m_wdata});
    check("wr_count",   {60'd0, wr_count},  64'(m_count % 16));

    // Requesters: a granted request leaves, the next queued one appears.
    if (drop_alu) alu_valid = 1'b0;
    if (drop_mem) mem_valid = 1'b0;
    if (drop_lnk) lnk_valid = 1'b0;
    if (!alu_valid && alu_q.size() > 0) begin
      e = alu_q.pop_front(); alu_valid = 1'b1; alu_reg = e.r; alu_data = e.d;
    end
    if (!mem_valid && mem_q.size() > 0) begin
      e = mem_q.pop_front(); mem_valid = 1'b1; mem_reg = e.r; mem_data = e.d;
    end
    if (!lnk_valid && lnk_q.size() > 0) begin
      e = lnk_q.pop_front(); lnk_valid = 1'b1; lnk_data = e.d;
    end
    rd_rs = rs;
    rd_rt = rt;
    rst_n = rst;

    if (held_alu) check("alu_hold", {27'd0, alu_valid, alu_reg, alu_data}, {27'd0, 1'b1, snap_alu});
    if (held_mem) check("mem_hold", {27'd0, mem_valid, mem_reg, mem_data}, {27'd0, 1'b1, snap_mem});
    if (held_lnk) check("lnk_hold", {31'd0, lnk_valid, lnk_data}, {31'd0, 1'b1, snap_lnk});
    #1;

    // Who should win this cycle
    who = "none";
    if (rst) begin
      if (lnk_valid)                   who = "lnk";
      else if (alu_valid && mem_valid) who = m_rr ? "mem" : "alu";
      else if (alu_valid)              who = "alu";
      else if (mem_valid)              who = "mem";
    end
    check("lnk_ready", {63'd0, lnk_ready}, {63'd0, who == "lnk"});
    check("alu_ready", {63'd0, alu_ready}, {63'd0, who == "alu"});
    check("mem_ready", {63'd0, mem_ready}, {63'd0, who == "mem"});
    check("hazard",    {63'd0, hazard},    {63'd0, exp_hazard(rs, rt)});

    // Advance model to the state after the coming edge
    if (!rst) begin
      m_rr = 0; m_wr = 0; m_jal = 0; m_wreg = '0; m_wdata = '0; m_count = 0;
    end else begin
      if (m_wr || m_jal) m_count++;
      m_wr  = 0;
      m_jal = 0;
      if (who == "lnk") begin
        m_jal = 1; m_wreg = 5'd31; m_wdata = lnk_data;
      end else if (who == "alu") begin
        m_rr = 1;
        if (alu_reg != 0) begin m_wr = 1; m_wreg = alu_reg; m_wdata = alu_data; end
      end else if (who == "mem") begin
        m_rr = 0;
        if (mem_reg != 0) begin m_wr = 1; m_wreg = mem_reg; m_wdata = mem_data; end
      end
    end
    drop_alu = (who == "alu");
    drop_mem = (who == "mem");
    drop_lnk = (who == "lnk");
    held_alu = alu_valid && !drop_alu; snap_alu = {alu_reg, alu_data};
    held_mem = mem_valid && !drop_mem; snap_mem = {mem_reg, mem_data};
    held_lnk = lnk_valid && !drop_lnk; snap_lnk = lnk_data;
    @(posedge clk);
  endtask

  task automatic drain(input logic [4:0] rs, input logic [4:0] rt);
    for (int i = 0; i < 80; i++) begin
      if (alu_q.size() == 0 && mem_q.size() == 0 && lnk_q.size() == 0 &&
          !alu_valid && !mem_valid && !lnk_valid && !m_wr && !m_jal) break;
      cycle(rs, rt, 1'b1);
    end
    cycle(rs, rt, 1'b1);
    cycle(rs, rt, 1'b1);
  endtask

  function automatic req_t rand_req();
    req_t r;
    logic [4:0] pick [8];
    pick = '{5'd0, 5'd3, 5'd4, 5'd5, 5'd7, 5'd31, 5'd1, 5'd2};
    r.r = ($urandom_range(0, 3) == 0) ? 5'($urandom) : pick[$urandom_range(0, 7)];
    r.d = $urandom;
    return r;
  endfunction

  initial begin
    logic [4:0] rs, rt;
    rst_n = 1'b0;
    alu_valid = 0; mem_valid = 0; lnk_valid = 0;
    alu_reg = '0; mem_reg = '0; alu_data = '0; mem_data = '0; lnk_data = '0;
    rd_rs = '0; rd_rt = '0;
    m_rr = 0; m_wr = 0; m_jal = 0; m_wreg = '0; m_wdata = '0; m_count = 0;
    repeat (2) @(posedge clk);
    cycle(0, 0, 1'b0);
    cycle(0, 0, 1'b1);

    // Single ALU write
    alu_q.push_back('{5'd5, 32'hDEADBEEF});
    drain(0, 0);

    // Continuous alu/mem contention alternates
    for (int i = 0; i < 3; i++) begin
      alu_q.push_back('{5'd3, 32'hA000_0000 + 32'(i)});
      mem_q.push_back('{5'd4, 32'hB000_0000 + 32'(i)});
    end
    drain(0, 0);

    // All three at once: link first, alu then mem
    lnk_q.push_back('{5'd31, 32'h0040_0010});
    alu_q.push_back('{5'd9, 32'h1111_1111});
    mem_q.push_back('{5'd10, 32'h2222_2222});
    drain(0, 0);

    // Write to r0 is accepted but dropped
    mem_q.push_back('{5'd0, 32'hCAFE_F00D});
    drain(0, 0);

    // Hazard on pending and strobing load, and none with zero sources
    mem_q.push_back('{5'd7, 32'h7777_7777});
    drain(0, 5'd7);
    mem_q.push_back('{5'd7, 32'h7777_7778});
    drain(0, 0);

    // Counter wraps in a 4-bit build
    for (int i = 0; i < 18; i++) alu_q.push_back('{5'(i % 30 + 1), $urandom});
    drain(0, 0);

    // Reset landing on a strobe cycle cancels it
    alu_q.push_back('{5'd12, 32'h1234_5678});
    cycle(0, 0, 1'b1);
    cycle(0, 0, 1'b0);
    cycle(0, 0, 1'b1);
    cycle(0, 0, 1'b1);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 2) == 0 && alu_q.size() < 2) alu_q.push_back(rand_req());
      if ($urandom_range(0, 2) == 0 && mem_q.size() < 2) mem_q.push_back(rand_req());
      if ($urandom_range(0, 7) == 0 && lnk_q.size() < 2) lnk_q.push_back(rand_req());
      rs = ($urandom_range(0, 2) == 0) ? 5'd0 : rand_req().r;
      rt = ($urandom_range(0, 2) == 0) ? 5'd0 : rand_req().r;
      cycle(rs, rt, ($urandom_range(0, 60) != 0));
    end
    drain(0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_write_arbiter.md
REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 The module SHALL have parameter CNT_W, default 16, giving the width of the issued-write counter.
REQ-002 The module SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-003 The module SHALL have port rst_n, input, 1, reset, synchronous and active-low.
REQ-004 The module SHALL have ports alu_valid in 1, alu_reg in 5, alu_data in 32, alu_ready out 1, forming the ALU writeback requester.
REQ-005 The module SHALL have ports mem_valid in 1, mem_reg in 5, mem_data in 32, mem_ready out 1, forming the load writeback requester.
REQ-006 The module SHALL have ports lnk_valid in 1, lnk_data in 32, lnk_ready out 1, forming the jal link requester; its target is always register 31.
REQ-007 The module SHALL have ports rd_rs in 5 and rd_rt in 5, the source registers of the decoding instruction, and hazard out 1.
REQ-008 The module SHALL have ports reg_write out 1, jal out 1, write_reg out 5, write_data out 32, driving the register file write port.
REQ-009 The module SHALL have port wr_count, output, CNT_W, giving the count of issued writes.

Function
REQ-010 A transfer SHALL occur on a rising edge where X_valid=1 and X_ready=1; at most one ready SHALL be high per cycle.
REQ-011 X_ready SHALL be combinational; it SHALL be 0 whenever X_valid=0 or rst_n=0.
REQ-012 Priority SHALL be: lnk first; otherwise round-robin between alu and mem using 1-bit rr_ptr (0 = alu preferred).
REQ-013 rr_ptr SHALL become 1 after an alu transfer and 0 after a mem transfer; lnk transfers and idle cycles SHALL leave it unchanged.
REQ-014 A sole valid requester SHALL be granted in the same cycle regardless of rr_ptr.
REQ-015 Requesters SHALL hold valid and payload stable until ready; the bench SHALL flag any violation.
REQ-016 Output stage FSM SHALL have states IDLE and ISSUE: ISSUE in the cycle after any transfer, else IDLE; ISSUE may repeat on back-to-back transfers.
REQ-017 After a lnk transfer, the next cycle SHALL have jal=1, reg_write=0, write_reg=31, write_data=lnk_data.
REQ-018 After an alu or mem transfer with target!=0, the next cycle SHALL have reg_write=1, jal=0, and write_reg/write_data equal to the transferred payload.
REQ-019 A transfer with target=0 SHALL be accepted (ready=1) but dropped: reg_write=0 and jal=0 next cycle, wr_count unchanged.
REQ-020 In IDLE, reg_write=0 and jal=0 SHALL hold, and write_reg/write_data SHALL hold their previous values.
REQ-021 Write latency SHALL be exactly 1 cycle from transfer edge to strobe, and each strobe SHALL last exactly 1 cycle per transfer.
REQ-022 wr_count SHALL increment by 1 on each cycle where reg_write or jal is 1, and SHALL wrap from 2^CNT_W-1 to 0.
REQ-023 hazard SHALL be combinational and SHALL be 1 iff rd_rs or rd_rt is nonzero and equals any of: alu_reg while alu_valid, mem_reg while mem_valid, 31 while lnk_valid, or write_reg while reg_write|jal.
REQ-024 All three requesters valid in the same cycle SHALL yield a lnk grant; alu and mem SHALL then wait, with rr_ptr unchanged.

Reset
REQ-025 While rst_n=0 at a rising edge, the block SHALL clear reg_write, jal, write_reg, write_data, wr_count, and rr_ptr to 0 and force the FSM to IDLE.
REQ-026 No transfer SHALL occur in any cycle with rst_n=0; a write pending in the output stage when reset asserts SHALL be cancelled, with no strobe after the reset edge.
REQ-027 The first grant after reset release SHALL use rr_ptr=0, so alu is preferred.

Verification
REQ-028 alu_valid=1, alu_reg=5, alu_data=0xDEADBEEF, others idle -> alu_ready=1 that cycle; next cycle reg_write=1, write_reg=5, write_data=0xDEADBEEF; wr_count=1.
REQ-029 alu and mem valid continuously with targets 3 and 4 -> grants alternate alu, mem, alu, mem; write_reg sequence 3,4,3,4 with no idle cycles.
REQ-030 lnk, alu, and mem valid together, lnk_data=0x00400010 -> lnk granted first; next cycle jal=1, write_reg=31; then alu, then mem.
REQ-031 mem_valid=1 with mem_reg=0 -> mem_ready=1; next cycle reg_write=0, jal=0, wr_count unchanged.
REQ-032 mem_valid=1 with mem_reg=7 and rd_rt=7 -> hazard=1; hazard stays 1 during the strobe cycle and is 0 the following cycle; rd_rs=rd_rt=0 -> hazard=0 always.
REQ-033 Case A: CNT_W=4 with 16 issued writes -> wr_count wraps to 0. Case B: rst_n=0 during ISSUE -> no strobe after the reset edge, all outputs 0.
